mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: request/ack handshake, byte-lane steering and load extension.
// Build option: define MEM_MISALIGN_CHECK_EN to trap misaligned H/W accesses instead of issuing them.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] ReadDataM,
    output logic        StallMem,
    output logic        MisalignM
);

    // state | meaning
    // IDLE  | no access outstanding; a new access issues its request here
    // WAIT  | request held, waiting for dmem_ack
    // DONE  | access complete; pipeline released for exactly one cycle
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      r_state;
    logic [31:0] r_rdata;
    logic        r_misalign;

    logic        w_access;
    logic        w_misalign;
    logic        w_go;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_f3_valid;
    logic        w_load_cap;
    logic        w_ack_ok;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_access  = MemWriteM | (ResultSrcM == 2'b01);

    // funct3[1:0] selects the size; the unused codes fall through to word
    assign w_is_byte = (funct3M[1:0] == 2'b00);
    assign w_is_half = (funct3M[1:0] == 2'b01);
    assign w_is_word = ~w_is_byte & ~w_is_half;

    assign w_f3_valid = (funct3M == 3'b000) | (funct3M == 3'b001) | (funct3M == 3'b010) |
                        (funct3M == 3'b100) | (funct3M == 3'b101);

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign = w_access &
                        ((w_is_half & ALUResultM[0]) |
                         (w_is_word & (ALUResultM[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    // A trapped access never reaches memory and never stalls
    assign w_go = w_access & ~w_misalign;

    assign dmem_req  = ((r_state == IDLE) & w_go) | (r_state == WAIT);
    assign dmem_we   = MemWriteM;
    assign dmem_addr = {ALUResultM[31:2], 2'b00};
    assign StallMem  = w_go & (r_state != DONE);

    assign w_ack_ok   = dmem_req & dmem_ack;
    assign w_load_cap = (ResultSrcM == 2'b01) & ~MemWriteM & w_f3_valid;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        if (w_is_byte) begin
            w_be    = 4'b0001 << ALUResultM[1:0];
            w_wdata = {4{WriteDataM[7:0]}};
        end else if (w_is_half) begin
            w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{WriteDataM[15:0]}};
        end
    end

    assign dmem_be    = w_be;
    assign dmem_wdata = w_wdata;

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (ALUResultM[1:0])
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            2'b11:   w_byte = dmem_rdata[31:24];
            default: w_byte = dmem_rdata[7:0];
        endcase
        w_half = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3M)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'h000000, w_byte};
            3'b101:  w_load_ext = {16'h0000, w_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rdata    <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign & (r_state == IDLE);
            case (r_state)
                IDLE:    if (w_go) r_state <= dmem_ack ? DONE : WAIT;
                WAIT:    if (dmem_ack) r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_ack_ok & w_load_cap)
                r_rdata <= w_load_ext;
        end
    end

    assign ReadDataM = r_rdata;
    assign MisalignM = r_misalign;

endmodule
